hazard_fwd_ctrl: RTL and testbench
==================================

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 Parameters SHALL be: REG_ADDR_W, 5, register-address width; CNT_W, 16, stall-counter width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning), clock and reset first:
  clk  in  1  single clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  id_valid  in  1  valid instruction in ID
  id_rs  in  REG_ADDR_W  ID source A
  id_rt  in  REG_ADDR_W  ID source B
  id_rd  in  REG_ADDR_W  ID destination
  id_wr_en  in  1  ID instruction writes register file
  id_is_load  in  1  ID instruction is a load
  ex_flush  in  1  branch/jump resolved taken; kill ID instruction
  mem_wait  in  1  data memory not ready; freeze pipeline
  stall  out  1  hold PC and IF/ID register
  bubble  out  1  load ID/EX with a NOP
  fwd_a_sel  out  2  operand-A forward-mux select for instruction in EX
  fwd_b_sel  out  2  operand-B forward-mux select for instruction in EX
  stall_cnt  out  CNT_W  load-use stall count (macro-dependent)

Function
REQ-003 Block SHALL track three stages internally: EX (valid, rs, rt, rd, wr, load), EXMEM (valid, rd, wr), MEMWB (valid, rd, wr).
REQ-004 Select encoding SHALL be: 00 register-file data, 01 EXMEM result, 10 MEMWB result; 11 SHALL never be driven.
REQ-005 fwd_a_sel/fwd_b_sel SHALL be registered, computed when the ID instruction advances into EX, valid for the whole cycle(s) that instruction occupies EX.
REQ-006 Select for source s SHALL be 01 if current EX valid, wr, rd!=0, rd==s; else 10 if current EXMEM valid, wr, rd!=0, rd==s; else 00 (EXMEM priority over MEMWB).
REQ-007 Register 0 SHALL never be forwarded.
REQ-008 FSM states SHALL be RUN, LU_STALL, MEM_WAIT.
REQ-009 Load-use hazard SHALL be: id_valid & EX valid & EX load & EX wr & EX rd!=0 & (EX rd==id_rs | EX rd==id_rt).
REQ-010 In RUN: mem_wait=1 -> MEM_WAIT; else hazard & !ex_flush -> LU_STALL; else stay RUN.
REQ-011 stall and bubble SHALL be combinational: hazard (no mem_wait, no flush) -> stall=1, bubble=1; mem_wait=1 -> stall=1, bubble=0; ex_flush=1 (no mem_wait) -> stall=0, bubble=1.
REQ-012 On a load-use stall, EX SHALL receive a bubble and selects SHALL become 00; EXMEM/MEMWB advance normally.
REQ-013 LU_STALL SHALL last exactly one cycle, then return to RUN (or MEM_WAIT if mem_wait=1).
REQ-014 In MEM_WAIT all internal stage registers and selects SHALL hold; return to RUN the cycle after mem_wait deasserts.
REQ-015 Priority SHALL be mem_wait > ex_flush > load-use hazard.
REQ-016 ex_flush SHALL insert a bubble into EX; a flushed instruction SHALL never be a forwarding source.
REQ-017 Normal advance SHALL shift ID->EX->EXMEM->MEMWB each cycle; MEMWB contents drop out.

Reset
REQ-018 rst_n low SHALL asynchronously clear all stage valids, set state RUN, fwd_a_sel=fwd_b_sel=00, stall_cnt=0; stall/bubble SHALL then evaluate 0.
REQ-019 Reset mid-stall or mid-MEM_WAIT SHALL abandon the operation; first cycle after release is RUN with empty stages.

Configuration
REQ-020 With HAZARD_STALL_CNT_EN defined, stall_cnt SHALL increment once per load-use stall cycle, saturating at all-ones; without it, stall_cnt SHALL be tied to 0 and no counter logic synthesized.

Structure
REQ-021 Package pipe_ctrl_pkg SHALL hold FWD_DATA/FWD_EX/FWD_MEM encodings, the FSM state enum, and REG_ADDR_W default.
REQ-022 A sub-module fwd_cmp (one source address vs. two destination tuples -> 2-bit select) SHALL be instantiated twice, for A and B.

Verification
REQ-023 add r3 in EX, ID sub r4,r3,r5 -> next cycle fwd_a_sel=01, fwd_b_sel=00, stall=0.
REQ-024 add r3 in EXMEM, nop in EX, ID uses r3 as rt -> fwd_b_sel=10; same rd in both EX and EXMEM -> 01.
REQ-025 lw r2 in EX, ID add r6,r2,r2 -> stall=1, bubble=1 one cycle; instruction enters EX with both selects 10; stall_cnt 0->1 with macro.
REQ-026 ID writes r0, next instruction reads r0 -> selects 00.
REQ-027 load-use hazard with mem_wait=1 for 3 cycles -> stall=1, bubble=0 three cycles, state held, then one LU_STALL cycle.
REQ-028 ex_flush=1 during load-use hazard -> stall=0, bubble=1; rst_n low during LU_STALL -> selects 00, state RUN immediately.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/forwarding controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;

  localparam logic [1:0] FWD_DATA = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_cmp.sv
// Forwarding comparator: one source address against the two older in-flight
// destinations, newest producer wins; register 0 is never forwarded.
module fwd_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic                  i_ex_v,
  input  logic                  i_ex_wr,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_mem_v,
  input  logic                  i_mem_wr,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  output logic [1:0]            o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = i_ex_v  & i_ex_wr  & (i_ex_rd  != '0) & (i_ex_rd  == i_src);
  assign w_mem_hit = i_mem_v & i_mem_wr & (i_mem_rd != '0) & (i_mem_rd == i_src);

  always_comb begin
    o_sel = FWD_DATA;
    if (w_ex_hit)       o_sel = FWD_EX;
    else if (w_mem_hit) o_sel = FWD_MEM;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use stall, flush bubble and operand-forwarding control for a 5-stage pipe.
// Define HAZARD_STALL_CNT_EN to build the saturating load-use stall counter.
module hazard_fwd_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  ex_flush,
  input  logic                  mem_wait,
  output logic                  stall,
  output logic                  bubble,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_ex_v;
  logic [REG_ADDR_W-1:0] r_ex_rs;
  logic [REG_ADDR_W-1:0] r_ex_rt;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_wr;
  logic                  r_ex_ld;
  logic                  r_mem_v;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_mem_wr;
  logic                  r_wb_v;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_wr;
  logic [1:0]            r_fwd_a;
  logic [1:0]            r_fwd_b;

  logic                  w_hazard;
  logic                  w_adv;
  logic [1:0]            w_sel_a;
  logic [1:0]            w_sel_b;
  logic                  w_unused_trace;

  // EX is always a bubble while in LU_STALL, so the state gate only guards the one-cycle rule.
  assign w_hazard = id_valid & r_ex_v & r_ex_ld & r_ex_wr & (r_ex_rd != '0) &
                    ((r_ex_rd == id_rs) | (r_ex_rd == id_rt)) & (r_state != LU_STALL);

  assign stall  = mem_wait | (w_hazard & ~ex_flush);
  assign bubble = ~mem_wait & (ex_flush | w_hazard);
  assign w_adv  = id_valid & ~bubble;

  assign w_unused_trace = ^{r_ex_rs, r_ex_rt, r_wb_v, r_wb_rd, r_wb_wr};

  fwd_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_src    (id_rs),
    .i_ex_v   (r_ex_v),
    .i_ex_wr  (r_ex_wr),
    .i_ex_rd  (r_ex_rd),
    .i_mem_v  (r_mem_v),
    .i_mem_wr (r_mem_wr),
    .i_mem_rd (r_mem_rd),
    .o_sel    (w_sel_a)
  );

  fwd_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_src    (id_rt),
    .i_ex_v   (r_ex_v),
    .i_ex_wr  (r_ex_wr),
    .i_ex_rd  (r_ex_rd),
    .i_mem_v  (r_mem_v),
    .i_mem_wr (r_mem_wr),
    .i_mem_rd (r_mem_rd),
    .o_sel    (w_sel_b)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN: begin
        if (mem_wait)                   w_state_nxt = MEM_WAIT;
        else if (w_hazard & ~ex_flush)  w_state_nxt = LU_STALL;
      end
      LU_STALL: w_state_nxt = mem_wait ? MEM_WAIT : RUN;
      MEM_WAIT: w_state_nxt = mem_wait ? MEM_WAIT : RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // Selects are captured for the instruction entering EX; bubbles carry FWD_DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_v   <= 1'b0;
      r_ex_rs  <= '0;
      r_ex_rt  <= '0;
      r_ex_rd  <= '0;
      r_ex_wr  <= 1'b0;
      r_ex_ld  <= 1'b0;
      r_mem_v  <= 1'b0;
      r_mem_rd <= '0;
      r_mem_wr <= 1'b0;
      r_wb_v   <= 1'b0;
      r_wb_rd  <= '0;
      r_wb_wr  <= 1'b0;
      r_fwd_a  <= FWD_DATA;
      r_fwd_b  <= FWD_DATA;
    end else if (!mem_wait) begin
      r_wb_v   <= r_mem_v;
      r_wb_rd  <= r_mem_rd;
      r_wb_wr  <= r_mem_wr;
      r_mem_v  <= r_ex_v;
      r_mem_rd <= r_ex_rd;
      r_mem_wr <= r_ex_wr;
      r_ex_v   <= w_adv;
      r_ex_rs  <= id_rs;
      r_ex_rt  <= id_rt;
      r_ex_rd  <= id_rd;
      r_ex_wr  <= id_wr_en;
      r_ex_ld  <= id_is_load;
      r_fwd_a  <= w_adv ? w_sel_a : FWD_DATA;
      r_fwd_b  <= w_adv ? w_sel_b : FWD_DATA;
    end
  end

  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;

`ifdef HAZARD_STALL_CNT_EN
  logic             w_lu_stall;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_lu_stall = w_hazard & ~ex_flush & ~mem_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_stall_cnt <= '0;
    else if (w_lu_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios plus random traffic
// against an in-order pipeline model of in-flight instructions.
module tb_hazard_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_wr_en, id_is_load, ex_flush, mem_wait;
  logic        stall, bubble;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_wr_en   (id_wr_en),
    .id_is_load (id_is_load),
    .ex_flush   (ex_flush),
    .mem_wait   (mem_wait),
    .stall      (stall),
    .bubble     (bubble),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // In-flight instructions, index 0 = in EX, 1 = EXMEM, 2 = MEMWB.
  typedef struct {
    bit v;
    bit wr;
    bit ld;
    int rd;
  } ins_t;

  ins_t       m_pipe [3];
  logic [1:0] m_a, m_b;
  int         m_cnt;

  function automatic void m_clear();
    for (int k = 0; k < 3; k++) m_pipe[k] = '{v:0, wr:0, ld:0, rd:0};
    m_a   = 2'b00;
    m_b   = 2'b00;
    m_cnt = 0;
  endfunction

  function automatic bit m_hazard();
    return id_valid && m_pipe[0].v && m_pipe[0].ld && m_pipe[0].wr && m_pipe[0].rd != 0 &&
           (m_pipe[0].rd == int'(id_rs) || m_pipe[0].rd == int'(id_rt));
  endfunction

  function automatic bit m_stall();
    return mem_wait || (m_hazard() && !ex_flush);
  endfunction

  function automatic bit m_bubble();
    return !mem_wait && (ex_flush || m_hazard());
  endfunction

  // Newest older producer of register s: EX gives code 1, EXMEM code 2, none 0.
  function automatic logic [1:0] m_src(input int s);
    for (int k = 0; k < 2; k++)
      if (m_pipe[k].v && m_pipe[k].wr && m_pipe[k].rd != 0 && m_pipe[k].rd == s)
        return (k == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic int exp_cnt();
`ifdef HAZARD_STALL_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic void m_clock();
    bit hz, kill;
    if (mem_wait) return;
    hz   = m_hazard();
    kill = ex_flush || hz;
    if (hz && !ex_flush && m_cnt < 65535) m_cnt++;
    m_a = (id_valid && !kill) ? m_src(int'(id_rs)) : 2'b00;
    m_b = (id_valid && !kill) ? m_src(int'(id_rt)) : 2'b00;
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = kill ? '{v:0, wr:0, ld:0, rd:0}
                     : '{v:id_valid, wr:id_wr_en, ld:id_is_load, rd:int'(id_rd)};
  endfunction

  task automatic drive(input bit v, input int rs, input int rt, input int rd,
                       input bit wr, input bit ld, input bit fl, input bit mw);
    @(negedge clk);
    id_valid   = v;
    id_rs      = 5'(rs);
    id_rt      = 5'(rt);
    id_rd      = 5'(rd);
    id_wr_en   = wr;
    id_is_load = ld;
    ex_flush   = fl;
    mem_wait   = mw;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {id_valid, id_wr_en, id_is_load, ex_flush, mem_wait} = '0;
    {id_rs, id_rt, id_rd} = '0;
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {id_valid, id_wr_en, id_is_load, ex_flush, mem_wait} = '0;
    {id_rs, id_rt, id_rd} = '0;
    m_clear();
    #1;
    n_vec++; if (stall !== 1'b0)      begin n_err++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_vec++; if (bubble !== 1'b0)     begin n_err++; $display("FAIL reset_bubble got %b exp 0", bubble); end
    n_vec++; if (fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL reset_fwd_a got %b exp 00", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL reset_fwd_b got %b exp 00", fwd_b_sel); end
    n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fwd_ex();
    do_reset();
    drive(1, 1, 2, 3, 1, 0, 0, 0); tick();           // add r3,r1,r2
    drive(1, 3, 5, 4, 1, 0, 0, 0);                   // sub r4,r3,r5
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL fwd_ex_stall got %b exp 0", stall); end
    tick();
    n_vec++; if (fwd_a_sel !== 2'b01) begin n_err++; $display("FAIL fwd_ex_a got %b exp 01", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL fwd_ex_b got %b exp 00", fwd_b_sel); end
  endtask

  task automatic test_fwd_mem();
    do_reset();
    drive(1, 1, 2, 3, 1, 0, 0, 0); tick();           // add r3
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();           // nop
    drive(1, 7, 3, 8, 1, 0, 0, 0); tick();           // reads r3 as rt
    n_vec++; if (fwd_b_sel !== 2'b10) begin n_err++; $display("FAIL fwd_mem_b got %b exp 10", fwd_b_sel); end
    n_vec++; if (fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL fwd_mem_a got %b exp 00", fwd_a_sel); end
    drive(1, 1, 2, 3, 1, 0, 0, 0); tick();           // add r3
    drive(1, 4, 5, 3, 1, 0, 0, 0); tick();           // add r3 again
    drive(1, 3, 0, 9, 1, 0, 0, 0); tick();           // r3 in EX and EXMEM
    n_vec++; if (fwd_a_sel !== 2'b01) begin n_err++; $display("FAIL fwd_prio_a got %b exp 01", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL fwd_prio_b got %b exp 00", fwd_b_sel); end
  endtask

  task automatic test_r0();
    do_reset();
    drive(1, 1, 1, 0, 1, 0, 0, 0); tick();           // writes r0
    drive(1, 0, 0, 5, 1, 0, 0, 0); tick();           // reads r0
    n_vec++; if (fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL r0_a got %b exp 00", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL r0_b got %b exp 00", fwd_b_sel); end
    drive(1, 1, 0, 0, 1, 1, 0, 0); tick();           // lw r0
    drive(1, 0, 0, 6, 1, 0, 0, 0);
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL r0_load_stall got %b exp 0", stall); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 0, 2, 1, 1, 0, 0); tick();           // lw r2
    drive(1, 2, 2, 6, 1, 0, 0, 0);                   // add r6,r2,r2
    n_vec++; if (stall !== 1'b1)  begin n_err++; $display("FAIL lu_stall got %b exp 1", stall); end
    n_vec++; if (bubble !== 1'b1) begin n_err++; $display("FAIL lu_bubble got %b exp 1", bubble); end
    tick();
    n_vec++; if (fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL lu_bubble_sel got %b exp 00", fwd_a_sel); end
    n_vec++; if (int'(stall_cnt) !== exp_cnt()) begin n_err++; $display("FAIL lu_cnt got %0d exp %0d", stall_cnt, exp_cnt()); end
    drive(1, 2, 2, 6, 1, 0, 0, 0);
    n_vec++; if (stall !== 1'b0 || bubble !== 1'b0) begin n_err++; $display("FAIL lu_release got %b%b exp 00", stall, bubble); end
    tick();
    n_vec++; if (fwd_a_sel !== 2'b10) begin n_err++; $display("FAIL lu_fwd_a got %b exp 10", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'b10) begin n_err++; $display("FAIL lu_fwd_b got %b exp 10", fwd_b_sel); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    drive(1, 3, 4, 1, 1, 0, 0, 0); tick();           // add r1
    drive(1, 1, 0, 2, 1, 1, 0, 0); tick();           // lw r2,(r1)
    for (int c = 0; c < 3; c++) begin
      drive(1, 2, 2, 6, 1, 0, 0, 1);
      n_vec++; if (stall !== 1'b1 || bubble !== 1'b0) begin n_err++; $display("FAIL mw_out c%0d got %b%b exp 10", c, stall, bubble); end
      tick();
      n_vec++; if (fwd_a_sel !== 2'b01) begin n_err++; $display("FAIL mw_hold c%0d got %b exp 01", c, fwd_a_sel); end
    end
    drive(1, 2, 2, 6, 1, 0, 0, 0);
    n_vec++; if (stall !== 1'b1 || bubble !== 1'b1) begin n_err++; $display("FAIL mw_lu got %b%b exp 11", stall, bubble); end
    tick();
    drive(1, 2, 2, 6, 1, 0, 0, 0);
    n_vec++; if (stall !== 1'b0 || bubble !== 1'b0) begin n_err++; $display("FAIL mw_done got %b%b exp 00", stall, bubble); end
    tick();
    n_vec++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin n_err++; $display("FAIL mw_fwd got %b %b exp 10 10", fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 1, 0, 2, 1, 1, 0, 0); tick();           // lw r2
    drive(1, 2, 2, 6, 1, 0, 1, 0);                   // hazard + flush
    n_vec++; if (stall !== 1'b0 || bubble !== 1'b1) begin n_err++; $display("FAIL flush_out got %b%b exp 01", stall, bubble); end
    tick();
    drive(1, 6, 6, 7, 1, 0, 0, 0);                   // reads flushed r6
    tick();
    n_vec++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL flush_src got %b %b exp 00 00", fwd_a_sel, fwd_b_sel); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 1, 0, 2, 1, 1, 0, 0); tick();           // lw r2
    drive(1, 2, 2, 6, 1, 0, 0, 0); tick();           // stall cycle taken, now in LU_STALL
    #2;
    rst_n = 1'b0;
    m_clear();
    #1;
    n_vec++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL rst_lu_sel got %b %b exp 00 00", fwd_a_sel, fwd_b_sel); end
    n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_lu_cnt got %0d exp 0", stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0, 2, 1, 0, 0, 0); tick();           // add r2 (not a load)
    drive(1, 2, 2, 6, 1, 0, 0, 0);
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_lu_after got %b exp 0", stall); end
    tick();
    n_vec++; if (fwd_a_sel !== 2'b01) begin n_err++; $display("FAIL rst_lu_fwd got %b exp 01", fwd_a_sel); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(9, 0) < 8, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
            $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 4, $urandom_range(9, 0) < 1,
            $urandom_range(9, 0) < 2);
      n_vec++; if (stall !== m_stall())   begin n_err++; $display("FAIL rnd_stall i%0d got %b exp %b", i, stall, m_stall()); end
      n_vec++; if (bubble !== m_bubble()) begin n_err++; $display("FAIL rnd_bubble i%0d got %b exp %b", i, bubble, m_bubble()); end
      tick();
      n_vec++; if (fwd_a_sel !== m_a) begin n_err++; $display("FAIL rnd_fwd_a i%0d got %b exp %b", i, fwd_a_sel, m_a); end
      n_vec++; if (fwd_b_sel !== m_b) begin n_err++; $display("FAIL rnd_fwd_b i%0d got %b exp %b", i, fwd_b_sel, m_b); end
      n_vec++; if (int'(stall_cnt) !== exp_cnt()) begin n_err++; $display("FAIL rnd_cnt i%0d got %0d exp %0d", i, stall_cnt, exp_cnt()); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {id_valid, id_wr_en, id_is_load, ex_flush, mem_wait} = '0;
    {id_rs, id_rt, id_rd} = '0;
    m_clear();
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_r0();
    test_load_use();
    test_mem_wait();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
